riscv_core_dpath_vec_load_seq: RTL and testbench

- Sequences a strided vector load of up to 8 x 32-bit elements through a val/rdy memory port.
- Assembles the returned elements into one 256-bit vector.
- Writes the vector through the vector register file's single write port.
- Owns the write-port mux: the vector ALU writeback keeps priority, with a bounded-starvation override. Sits between decode/issue, the data memory port and the vector regfile.

---
 rtl/riscv_vec_pkg.sv | 21 ++
 rtl/vec_elem_collector.sv | 27 ++
 rtl/riscv_core_dpath_vec_load_seq.sv | 141 ++++++++++++++
 tb/tb_riscv_core_dpath_vec_load_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_vec_pkg.sv
// Shared widths, FSM encoding and helpers for the vector load sequencer slice.
package riscv_vec_pkg;

    localparam int unsigned VLEN_MAX = 8;
    localparam int unsigned ELEM_W   = 32;
    localparam int unsigned VREG_W   = 256;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } vload_state_e;

    // Element counts above the architectural maximum saturate.
    function automatic logic [CNT_W-1:0] clamp_vl(input logic [CNT_W-1:0] vl);
        return (vl > CNT_W'(VLEN_MAX)) ? CNT_W'(VLEN_MAX) : vl;
    endfunction

endpackage

// File: rtl/vec_elem_collector.sv
// Gathers in-order 32-bit load responses into a 256-bit vector buffer.
module vec_elem_collector
    import riscv_vec_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wen,
    input  logic [ELEM_W-1:0] wdata,
    output logic [VREG_W-1:0] vbuf,
    output logic [CNT_W-1:0]  recv
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vbuf <= '0;
            recv <= '0;
        end else if (clr) begin
            vbuf <= '0;
            recv <= '0;
        end else if (wen && (recv < CNT_W'(VLEN_MAX))) begin
            vbuf[32'(recv[2:0]) * ELEM_W +: ELEM_W] <= wdata;
            recv <= recv + CNT_W'(1);
        end
    end

endmodule

// File: rtl/riscv_core_dpath_vec_load_seq.sv
// Strided vector load sequencer: issues element reads, collects them, and
// arbitrates the single vector regfile write port against ALU writeback.
module riscv_core_dpath_vec_load_seq
    import riscv_vec_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic [4:0]   req_waddr,
    input  logic [31:0]  req_base,
    input  logic [31:0]  req_stride,
    input  logic [3:0]   req_vl,
    output logic         memreq_val,
    input  logic         memreq_rdy,
    output logic [31:0]  memreq_addr,
    input  logic         memresp_val,
    input  logic [31:0]  memresp_data,
    input  logic         alu_wen,
    input  logic [4:0]   alu_waddr,
    input  logic [255:0] alu_wdata,
    output logic         alu_stall,
    output logic         rf_wen_p,
    output logic [4:0]   rf_waddr_p,
    output logic [255:0] rf_wdata_p,
    output logic         busy,
    output logic         done
);

    vload_state_e       state;
    logic [4:0]         waddr_q;
    logic [31:0]        addr_q;
    logic [31:0]        stride_q;
    logic [CNT_W-1:0]   vl_q;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   recv;
    logic [VREG_W-1:0]  vbuf;
    logic [7:0]         starve;

    logic               accept;
    logic               issue_fire;
    logic               resp_take;
    logic               load_win;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   issued_nxt;
    logic [CNT_W-1:0]   recv_nxt;

    assign accept      = (state == ST_IDLE) && req_val;
    assign outstanding = issued - recv;
    assign issue_fire  = memreq_val && memreq_rdy;
    assign resp_take   = memresp_val && ((state == ST_ISSUE) || (state == ST_WAIT));
    assign issued_nxt  = issued + CNT_W'(issue_fire);
    assign recv_nxt    = recv + CNT_W'(resp_take);
    assign load_win    = !alu_wen || (starve >= 8'(STARVE_LIMIT));

    vec_elem_collector u_collector (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .wen     (resp_take),
        .wdata   (memresp_data),
        .vbuf    (vbuf),
        .recv    (recv)
    );

    always_comb begin
        req_rdy     = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        memreq_val  = (state == ST_ISSUE) && (issued < vl_q)
                      && (outstanding < CNT_W'(MAX_OUTSTANDING));
        memreq_addr = addr_q;
        rf_wen_p    = alu_wen;
        rf_waddr_p  = alu_waddr;
        rf_wdata_p  = alu_wdata;
        alu_stall   = 1'b0;
        done        = 1'b0;
        if ((state == ST_WRITE) && load_win) begin
            rf_wen_p   = 1'b1;
            rf_waddr_p = waddr_q;
            rf_wdata_p = vbuf;
            alu_stall  = alu_wen;
            done       = 1'b1;
        end
    end

    // addr_q carries base + issued*stride as a running sum, avoiding a multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            waddr_q  <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            vl_q     <= '0;
            issued   <= '0;
            starve   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    starve <= '0;
                    if (req_val) begin
                        waddr_q  <= req_waddr;
                        addr_q   <= req_base;
                        stride_q <= req_stride;
                        vl_q     <= clamp_vl(req_vl);
                        issued   <= '0;
                        state    <= (clamp_vl(req_vl) == '0) ? ST_WRITE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire) begin
                        addr_q <= addr_q + stride_q;
                        issued <= issued_nxt;
                    end
                    if (recv_nxt == vl_q) begin
                        state <= ST_WRITE;
                    end else if (issued_nxt == vl_q) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (recv_nxt == vl_q) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (load_win) begin
                        starve <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        starve <= starve + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_dpath_vec_load_seq.sv
// Directed bench for the vector load sequencer with a 1-cycle in-order memory responder.
module tb_riscv_core_dpath_vec_load_seq;

    logic         clk;
    logic         reset_n;
    logic         req_val;
    logic         req_rdy;
    logic [4:0]   req_waddr;
    logic [31:0]  req_base;
    logic [31:0]  req_stride;
    logic [3:0]   req_vl;
    logic         memreq_val;
    logic         memreq_rdy;
    logic [31:0]  memreq_addr;
    logic         memresp_val;
    logic [31:0]  memresp_data;
    logic         alu_wen;
    logic [4:0]   alu_waddr;
    logic [255:0] alu_wdata;
    logic         alu_stall;
    logic         rf_wen_p;
    logic [4:0]   rf_waddr_p;
    logic [255:0] rf_wdata_p;
    logic         busy;
    logic         done;

    int           vectors;
    int           errors;
    int           fire_idx;
    logic [31:0]  data_off;
    logic         resp_en;
    logic [31:0]  addr_log[$];
    logic [31:0]  resp_q[$];

    riscv_core_dpath_vec_load_seq #(
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_waddr    (req_waddr),
        .req_base     (req_base),
        .req_stride   (req_stride),
        .req_vl       (req_vl),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memreq_addr  (memreq_addr),
        .memresp_val  (memresp_val),
        .memresp_data (memresp_data),
        .alu_wen      (alu_wen),
        .alu_waddr    (alu_waddr),
        .alu_wdata    (alu_wdata),
        .alu_stall    (alu_stall),
        .rf_wen_p     (rf_wen_p),
        .rf_waddr_p   (rf_waddr_p),
        .rf_wdata_p   (rf_wdata_p),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: accepted request k answers with data_off + k + 1 one cycle later.
    always @(posedge clk) begin
        if (memresp_val && resp_q.size() > 0) void'(resp_q.pop_front());
        if (memreq_val && memreq_rdy) begin
            addr_log.push_back(memreq_addr);
            resp_q.push_back(data_off + 32'(fire_idx) + 32'd1);
            fire_idx++;
        end
        #1;
        if (resp_en && resp_q.size() > 0) begin
            memresp_val  = 1'b1;
            memresp_data = resp_q[0];
        end else begin
            memresp_val  = 1'b0;
            memresp_data = '0;
        end
    end

    function automatic logic [255:0] exp_vec(input logic [31:0] off, input int n);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*32 +: 32] = off + 32'(k) + 32'd1;
        return v;
    endfunction

    task automatic start_req(input logic [4:0] wa, input logic [31:0] base,
                             input logic [31:0] stride, input logic [3:0] vl);
        @(negedge clk);
        addr_log.delete();
        fire_idx   = 0;
        req_waddr  = wa;
        req_base   = base;
        req_stride = stride;
        req_vl     = vl;
        req_val    = 1'b1;
        @(posedge clk);
        #1 req_val = 1'b0;
    endtask

    task automatic wait_done(input int max, output int idx, output logic [255:0] d,
                             output logic [4:0] wa, output logic wen, output logic stl);
        idx = -1; d = '0; wa = '0; wen = 1'b0; stl = 1'b0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                idx = i; d = rf_wdata_p; wa = rf_waddr_p; wen = rf_wen_p; stl = alu_stall;
                break;
            end
        end
        if (idx < 0) begin
            vectors++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", max);
        end else begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || req_rdy !== 1'b1) begin
                errors++;
                $display("FAIL after_done: done=%b busy=%b req_rdy=%b exp 0 0 1", done, busy, req_rdy);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_val = 1'b0; req_waddr = '0; req_base = '0; req_stride = '0;
        req_vl = '0; memreq_rdy = 1'b1; alu_wen = 1'b0; alu_waddr = '0; alu_wdata = '0;
        memresp_val = 1'b0; memresp_data = '0; resp_en = 1'b1; data_off = '0; fire_idx = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_rdy, memreq_val, alu_stall, rf_wen_p, busy, done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctl: got %b exp 100000",
                     {req_rdy, memreq_val, alu_stall, rf_wen_p, busy, done});
        end
        vectors++;
        if (rf_waddr_p !== 5'd0 || rf_wdata_p !== '0) begin
            errors++;
            $display("FAIL reset_rf: waddr %h wdata %h exp 0", rf_waddr_p, rf_wdata_p);
        end
    endtask

    task automatic test_basic();
        int idx; logic [255:0] d; logic [4:0] wa; logic wen, stl;
        data_off = 32'h0;
        start_req(5'd5, 32'h1000, 32'd4, 4'd8);
        wait_done(40, idx, d, wa, wen, stl);
        vectors++;
        if (idx !== 10) begin errors++; $display("FAIL basic_latency: got %0d exp 10", idx); end
        vectors++;
        if (wa !== 5'd5 || wen !== 1'b1 || stl !== 1'b0) begin
            errors++; $display("FAIL basic_wport: waddr %0d wen %b stall %b exp 5 1 0", wa, wen, stl);
        end
        vectors++;
        if (d !== exp_vec(32'h0, 8)) begin
            errors++; $display("FAIL basic_data: got %h exp %h", d, exp_vec(32'h0, 8));
        end
        vectors++;
        if (addr_log.size() !== 8) begin
            errors++; $display("FAIL basic_nreq: got %0d exp 8", addr_log.size());
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (addr_log[k] !== 32'h1000 + 32'(k) * 32'd4) begin
                errors++; $display("FAIL basic_addr%0d: got %h exp %h", k, addr_log[k], 32'h1000 + 32'(k) * 32'd4);
            end
        end
    endtask

    task automatic test_partial();
        int idx; logic [255:0] d; logic [4:0] wa; logic wen, stl;
        logic [31:0] exp_a[3];
        exp_a = '{32'h8, 32'h4, 32'h0};
        data_off = 32'h100;
        start_req(5'd9, 32'h8, 32'hFFFF_FFFC, 4'd3);
        wait_done(30, idx, d, wa, wen, stl);
        vectors++;
        if (idx !== 5) begin errors++; $display("FAIL partial_latency: got %0d exp 5", idx); end
        vectors++;
        if (wa !== 5'd9 || d !== exp_vec(32'h100, 3)) begin
            errors++; $display("FAIL partial_data: waddr %0d data %h exp 9 %h", wa, d, exp_vec(32'h100, 3));
        end
        vectors++;
        if (addr_log.size() !== 3) begin
            errors++; $display("FAIL partial_nreq: got %0d exp 3", addr_log.size());
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (addr_log[k] !== exp_a[k]) begin
                errors++; $display("FAIL partial_addr%0d: got %h exp %h", k, addr_log[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_outstanding();
        int idx; logic [255:0] d; logic [4:0] wa; logic wen, stl;
        data_off = 32'h200;
        resp_en  = 1'b0;
        start_req(5'd10, 32'h2000, 32'd8, 4'd8);
        repeat (8) @(negedge clk);
        vectors++;
        if (addr_log.size() !== 4 || memreq_val !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL outst_limit: nreq %0d memreq_val %b busy %b exp 4 0 1", addr_log.size(), memreq_val, busy);
        end
        resp_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (memresp_val !== 1'b1 || memreq_val !== 1'b0) begin
            errors++; $display("FAIL outst_first_resp: resp %b memreq_val %b exp 1 0", memresp_val, memreq_val);
        end
        wait_done(60, idx, d, wa, wen, stl);
        vectors++;
        if (d !== exp_vec(32'h200, 8) || wa !== 5'd10) begin
            errors++; $display("FAIL outst_data: waddr %0d data %h exp 10 %h", wa, d, exp_vec(32'h200, 8));
        end
        vectors++;
        if (addr_log.size() !== 8 || addr_log[7] !== 32'h2038) begin
            errors++; $display("FAIL outst_nreq: got %0d last %h exp 8 2038", addr_log.size(), addr_log[7]);
        end
    endtask

    task automatic test_contention();
        int idx; logic [255:0] d; logic [4:0] wa; logic wen, stl;
        data_off  = 32'h300;
        alu_wen   = 1'b1;
        alu_waddr = 5'd7;
        alu_wdata = {8{32'hDEAD_BEEF}};
        start_req(5'd12, 32'h40, 32'd4, 4'd2);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                vectors++;
                if (done !== 1'b0 || alu_stall !== 1'b0 || rf_wen_p !== 1'b1 || rf_waddr_p !== 5'd7
                    || rf_wdata_p !== {8{32'hDEAD_BEEF}} || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL contend_alu_c%0d: done %b stall %b wen %b waddr %0d busy %b exp 0 0 1 7 1",
                             i, done, alu_stall, rf_wen_p, rf_waddr_p, busy);
                end
            end
        end
        wait_done(5, idx, d, wa, wen, stl);
        vectors++;
        if (idx !== 1 || stl !== 1'b1 || wen !== 1'b1) begin
            errors++; $display("FAIL contend_override: idx %0d stall %b wen %b exp 1 1 1", idx, stl, wen);
        end
        vectors++;
        if (wa !== 5'd12 || d !== exp_vec(32'h300, 2)) begin
            errors++; $display("FAIL contend_data: waddr %0d data %h exp 12 %h", wa, d, exp_vec(32'h300, 2));
        end
        vectors++;
        if (alu_stall !== 1'b0 || rf_waddr_p !== 5'd7) begin
            errors++; $display("FAIL contend_release: stall %b waddr %0d exp 0 7", alu_stall, rf_waddr_p);
        end
        alu_wen = 1'b0; alu_waddr = '0; alu_wdata = '0;
    endtask

    task automatic test_edge_vl();
        int idx; logic [255:0] d; logic [4:0] wa; logic wen, stl;
        start_req(5'd3, 32'h5000, 32'd4, 4'd0);
        wait_done(10, idx, d, wa, wen, stl);
        vectors++;
        if (idx !== 1 || addr_log.size() !== 0) begin
            errors++; $display("FAIL vl0_timing: idx %0d nreq %0d exp 1 0", idx, addr_log.size());
        end
        vectors++;
        if (wa !== 5'd3 || d !== '0 || wen !== 1'b1) begin
            errors++; $display("FAIL vl0_data: waddr %0d wen %b data %h exp 3 1 0", wa, wen, d);
        end
        data_off = 32'h400;
        start_req(5'd4, 32'h6000, 32'h10, 4'd12);
        wait_done(40, idx, d, wa, wen, stl);
        vectors++;
        if (idx !== 10 || addr_log.size() !== 8) begin
            errors++; $display("FAIL vl12_clamp: idx %0d nreq %0d exp 10 8", idx, addr_log.size());
        end
        vectors++;
        if (d !== exp_vec(32'h400, 8) || addr_log[7] !== 32'h6070) begin
            errors++; $display("FAIL vl12_data: data %h last %h exp %h 6070", d, addr_log[7], exp_vec(32'h400, 8));
        end
    endtask

    task automatic test_reset_mid();
        int idx; logic [255:0] d; logic [4:0] wa; logic wen, stl;
        data_off = 32'h500;
        start_req(5'd6, 32'h7000, 32'd4, 4'd8);
        repeat (3) @(negedge clk);
        vectors++;
        if (addr_log.size() !== 2) begin
            errors++; $display("FAIL rstmid_issued: got %0d exp 2", addr_log.size());
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({req_rdy, memreq_val, rf_wen_p, busy, done} !== 5'b10000) begin
            errors++; $display("FAIL rstmid_async: got %b exp 10000", {req_rdy, memreq_val, rf_wen_p, busy, done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || resp_q.size() !== 0) begin
            errors++; $display("FAIL rstmid_drain: busy %b pending %0d exp 0 0", busy, resp_q.size());
        end
        data_off = 32'h600;
        start_req(5'd8, 32'h8000, 32'd4, 4'd4);
        wait_done(30, idx, d, wa, wen, stl);
        vectors++;
        if (idx !== 6 || wa !== 5'd8 || d !== exp_vec(32'h600, 4)) begin
            errors++; $display("FAIL rstmid_next: idx %0d waddr %0d data %h exp 6 8 %h", idx, wa, d, exp_vec(32'h600, 4));
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_basic();
        test_partial();
        test_outstanding();
        test_contention();
        test_edge_vl();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
